alu_issue_arbiter: RTL

//  Shares the single-cycle ALU (adder/logic uops decoded by Alu_ctrl) between two uop

---
 rtl/alu_issue_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU between two issue slots, with one registered output stage.
// Optional ALU_ARB_AGE_EN adds per-slot starvation counters that force a grant after STARVE_LIMIT losses.
module alu_issue_arbiter #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][6:0]       req_itype_i,
    input  logic [1:0][2:0]       req_funct3_i,
    input  logic [1:0][6:0]       req_funct7_i,
    input  logic [1:0][XLEN-1:0]  req_src1_i,
    input  logic [1:0][XLEN-1:0]  req_src2_i,
    input  logic [1:0][TAG_W-1:0] req_tag_i,
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic [6:0]            alu_itype,
    output logic [2:0]            alu_funct3,
    output logic [6:0]            alu_funct7,
    output logic [XLEN-1:0]       alu_src1,
    output logic [XLEN-1:0]       alu_src2,
    output logic [TAG_W-1:0]      alu_tag,
    output logic                  alu_src_id,
    input  logic                  flush
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [6:0]       itype;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [XLEN-1:0]  src1;
        logic [XLEN-1:0]  src2;
        logic [TAG_W-1:0] tag;
        logic             src_id;
    } uop_t;

    state_e     state_q, state_d;
    uop_t       uop_q, uop_d;
    logic       ptr_q, ptr_d;
    logic       can_accept;
    logic       any_valid;
    logic       gnt_slot;
    logic [1:0] grant;
    logic       xfer;

`ifdef ALU_ARB_AGE_EN
    localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIMIT);
    logic [1:0][1:0] starve_q, starve_d;
`else
    logic [31:0] unused_starve_limit;
    assign unused_starve_limit = 32'(STARVE_LIMIT);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        can_accept = (state_q == EMPTY) | alu_ready;
        any_valid  = |req_valid;
        if (&req_valid) gnt_slot = ptr_q;
        else            gnt_slot = req_valid[1];
`ifdef ALU_ARB_AGE_EN
        // A saturated slot overrides the pointer; slot 0 wins a tie.
        if (req_valid[0] && starve_q[0] == STARVE_MAX)      gnt_slot = 1'b0;
        else if (req_valid[1] && starve_q[1] == STARVE_MAX) gnt_slot = 1'b1;
`endif
        grant = 2'b00;
        if (any_valid) grant[gnt_slot] = 1'b1;

        // Held low while reset is asserted so no handshake can complete into a clearing stage.
        req_ready = (can_accept && !flush && reset) ? grant : 2'b00;
        xfer      = |(req_valid & req_ready);

        if (xfer)                   state_d = FULL;
        else if (flush | alu_ready) state_d = EMPTY;
        else                        state_d = state_q;

        uop_d = uop_q;
        if (xfer) begin
            uop_d.itype  = req_itype_i[gnt_slot];
            uop_d.funct3 = req_funct3_i[gnt_slot];
            uop_d.funct7 = req_funct7_i[gnt_slot];
            uop_d.src1   = req_src1_i[gnt_slot];
            uop_d.src2   = req_src2_i[gnt_slot];
            uop_d.tag    = req_tag_i[gnt_slot];
            uop_d.src_id = gnt_slot;
        end

        ptr_d = xfer ? ~gnt_slot : ptr_q;
    end

`ifdef ALU_ARB_AGE_EN
    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                starve_d[i] = 2'd0;
            end else if (xfer) begin
                if (gnt_slot == 1'(i))
                    starve_d[i] = 2'd0;
                else if (req_valid[i] && starve_q[i] != STARVE_MAX)
                    starve_d[i] = starve_q[i] + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: payload flops are reset too, because the outputs must read zero while the stage is cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            uop_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;
            ptr_q   <= ptr_d;
        end
    end

    assign alu_valid  = (state_q == FULL);
    assign alu_itype  = uop_q.itype;
    assign alu_funct3 = uop_q.funct3;
    assign alu_funct7 = uop_q.funct7;
    assign alu_src1   = uop_q.src1;
    assign alu_src2   = uop_q.src2;
    assign alu_tag    = uop_q.tag;
    assign alu_src_id = uop_q.src_id;

endmodule
